// File: rtl/sp_ram_fifo_pkg.sv
// Shared constants and types for the FIFO controller that drives the 8-entry single-port RAM.
package sp_ram_fifo_pkg;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef enum logic {
    WR_FIRST = 1'b0,
    RD_FIRST = 1'b1
  } prio_e;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam cnt_t CNT_EMPTY = cnt_t'(0);
  localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);

endpackage

// File: rtl/sp_ram.sv
// 8-entry single-port RAM: synchronous write, asynchronous read.
module sp_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  din_i,
  output logic [WIDTH-1:0]  dout_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  // storage write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/sp_rw_arbiter.sv
// Grants the single RAM port to a write or a read; contested cycles alternate via prio.
module sp_rw_arbiter (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_req_i,
  input  logic                   rd_req_i,
  output logic                   wr_gnt_o,
  output logic                   rd_gnt_o,
  output sp_ram_fifo_pkg::prio_e prio_o
);

  import sp_ram_fifo_pkg::*;

  prio_e prio_q;
  prio_e prio_d;

  // grant selection and priority update (loser of a contest is favoured next)
  always_comb begin
    wr_gnt_o = 1'b0;
    rd_gnt_o = 1'b0;
    prio_d   = prio_q;
    if (wr_req_i && rd_req_i) begin
      if (prio_q == WR_FIRST) begin
        wr_gnt_o = 1'b1;
        prio_d   = RD_FIRST;
      end else begin
        rd_gnt_o = 1'b1;
        prio_d   = WR_FIRST;
      end
    end else begin
      wr_gnt_o = wr_req_i;
      rd_gnt_o = rd_req_i;
    end
  end

  // priority register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= WR_FIRST;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller: maps push/pop valid-ready streams onto one RAM port and registers the pop data.
module sp_ram_fifo_ctrl #(
  parameter int WIDTH  = sp_ram_fifo_pkg::WIDTH,
  parameter int ADDR_W = sp_ram_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W:0]   level,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  input  logic [WIDTH-1:0]  ram_dout
);

  import sp_ram_fifo_pkg::*;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic  wr_req_s, rd_req_s;
  logic  wr_gnt_s, rd_gnt_s;
  prio_e prio_s;

  assign wr_req_s = in_valid && (cnt_q != CNT_FULL);
  assign rd_req_s = (cnt_q != CNT_EMPTY) && (!out_valid_q || out_ready);

  sp_rw_arbiter u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_req_i (wr_req_s),
    .rd_req_i (rd_req_s),
    .wr_gnt_o (wr_gnt_s),
    .rd_gnt_o (rd_gnt_s),
    .prio_o   (prio_s)
  );

  // in_ready mirrors the write grant so a push never needs to be retracted
  assign in_ready = (cnt_q != CNT_FULL) && (!rd_req_s || (prio_s == WR_FIRST));

  // RAM port drive and next-state for pointers, occupancy and the output stage
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ram_we      = 1'b0;
    ram_addr    = rd_ptr_q;
    if (wr_gnt_s) begin
      ram_we   = 1'b1;
      ram_addr = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
      cnt_d    = cnt_q + cnt_t'(1);
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if (rd_gnt_s) begin
      out_data_d  = ram_dout;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ptr_t'(1);
      cnt_d       = cnt_q - cnt_t'(1);
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= ptr_t'(0);
      rd_ptr_q    <= ptr_t'(0);
      cnt_q       <= CNT_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ram_din   = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = cnt_q + cnt_t'(out_valid_q);

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Scoreboard bench for sp_ram_fifo_ctrl driving the real sp_ram.
module tb_sp_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] level;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  sp_ram #(.WIDTH(8), .ADDR_W(3)) u_ram (
    .clk_i(clk), .we_i(ram_we), .addr_i(ram_addr), .din_i(ram_din), .dout_o(ram_dout)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];
  int         model_lvl = 0;
  int         wr_idx = 0;
  bit         last_push, last_pop, samp_we, prev_we;
  int         pops;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge, update scoreboard, return #1 after posedge
  task automatic cycle();
    @(negedge clk);
    last_push = 1'b0;
    last_pop  = 1'b0;
    samp_we   = ram_we;
    if (!rst) begin
      check_val("level", 32'(level), 32'(model_lvl));
      if (model_lvl == 9) check_val("full_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) begin
        check_val("push_we", 32'(ram_we), 32'd1);
        check_val("push_addr", 32'(ram_addr), 32'(wr_idx % 8));
        check_val("push_din", 32'(ram_din), 32'(in_data));
        sb_q.push_back(in_data);
        wr_idx++;
        model_lvl++;
        last_push = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: observed 0x%0h expected no item", out_data);
        end else begin
          check_val("pop_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
        model_lvl--;
        last_pop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    model_lvl = 0;
    wr_idx    = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    model_reset();

    // reset state while idle
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_ram_we", 32'(ram_we), 32'd0);
    check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
    cycle();

    // fill to level 9 with the consumer stalled
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    for (int i = 0; i < 40 && wr_idx < 9; i++) begin
      cycle();
      if (last_push) in_data = in_data + 8'd1;
    end
    check_val("fill_count", 32'(wr_idx), 32'd9);
    check_val("fill_level", 32'(level), 32'd9);
    check_val("fill_head", 32'(out_data), 32'h11);
    for (int i = 0; i < 3; i++) cycle();
    check_val("held_off", 32'(wr_idx), 32'd9);

    // drain back-to-back
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check_val("drain_valid", 32'(out_valid), 32'd1);
      cycle();
    end
    check_val("drain_out_valid", 32'(out_valid), 32'd0);
    check_val("drain_level", 32'(level), 32'd0);
    check_val("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    // simultaneous streaming: grants alternate, 20 items through wrap
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h40; pops = 0;
    for (int i = 0; i < 100 && pops < 20; i++) begin
      cycle();
      if (i >= 2) check_val("alternate", 32'(samp_we), 32'(!prev_we));
      prev_we = samp_we;
      if (last_push) in_data = in_data + 8'd1;
      if (last_pop) pops++;
    end
    check_val("stream_pops", 32'(pops), 32'd20);
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sb_q.size() > 0; i++) cycle();
    check_val("stream_sb_empty", 32'(sb_q.size()), 32'd0);
    cycle();
    check_val("stream_level", 32'(level), 32'd0);

    // single push latency
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    cycle();
    check_val("a5_pushed", 32'(last_push), 32'd1);
    in_valid = 1'b0;
    check_val("a5_not_yet", 32'(out_valid), 32'd0);
    cycle();
    check_val("a5_valid", 32'(out_valid), 32'd1);
    check_val("a5_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check_val("a5_consumed", 32'(out_valid), 32'd0);

    // reset mid-operation with a push pending
    in_valid = 1'b1; in_data = 8'h60; out_ready = 1'b0;
    for (int i = 0; i < 30 && model_lvl < 5; i++) begin
      cycle();
      if (last_push) in_data = in_data + 8'd1;
    end
    check_val("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1; in_data = 8'hEE;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_rd_ptr", 32'(ram_addr), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h3C;
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) cycle();
    check_val("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);
    check_val("post_rst_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
